axi_protocol_checker: RTL and testbench
=======================================

Name: axi_protocol_checker

Overview:
- Synthesizable, parametrised AXI3 protocol checker. Passively taps one master/slave link and drives no AXI signal.
- Tracks outstanding write and read bursts and checks beat counts against wlast/rlast.
- Checks VALID/payload stability, burst legality and response ordering.
- Reports results as sticky error bits, a one-cycle error pulse and the code of the first error. Sits next to the interface in both the testbench and the FPGA bring-up top.

Parameters:
- ID_W, 4, width of all ID fields
- ADDR_W, 32, address width
- DATA_W, 32, data width; STRB_W = DATA_W/8
- DEPTH, 8, maximum outstanding AW and AR bursts tracked (power of 2)
- CHK_WRAP_LEN, 1, when 1, wrap bursts with len not in {1,3,7,15} are errors

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- AXI inputs (all sampled on posedge clk), widths as follows:
  - awid/wid/bid/arid/rid: ID_W
  - awaddr/araddr: ADDR_W
  - awlen/arlen: 4
  - awsize/arsize: 3
  - awburst/arburst/bresp/rresp: 2
  - wdata/rdata: DATA_W
  - wstrb: STRB_W
  - every valid/ready/wlast/rlast: 1
- err_clr  in  1  clears err_sticky and first_err
- err_sticky  out  12  sticky error bits
- err_pulse  out  1  high one cycle when any new error bit is detected
- first_err  out  4  index of the first error since reset/clear; valid when err_sticky != 0
- wr_outstanding  out  $clog2(DEPTH)+1  AW bursts accepted whose last W beat is not yet seen
- rd_outstanding  out  $clog2(DEPTH)+1  AR bursts accepted whose rlast is not yet seen

Behaviour:
- Reset: all outputs 0, FIFOs empty, beat counters 0, completed-write counter 0, stability trackers cleared. Reset mid-burst discards all tracking state.
- Handshake on a channel means valid && ready at the posedge. Error bits are registered and visible the cycle after the offending edge.
- Error bits:
  - 0 AW_STABLE, 1 W_STABLE, 2 AR_STABLE, 3 B_STABLE, 4 R_STABLE
  - 5 AW_BURST, 6 AR_BURST
  - 7 WLAST, 8 RLAST
  - 9 W_ORDER (W beat with no outstanding AW, or B with no completed write burst)
  - 10 R_ORDER (R beat with no outstanding AR)
  - 11 OVERFLOW
- Stability: if valid && !ready at edge N, then at edge N+1 valid must be 1 and every payload field (ID, addr, len, size, burst, data, strb, last, resp as applicable) must be equal to edge N. Otherwise set the channel's STABLE bit.
- Burst legality, checked on the AW/AR handshake:
  - burst == 3 is an error.
  - size > log2(STRB_W) is an error.
  - For burst == 2 (wrap): addr must be aligned to 1<<size, and if CHK_WRAP_LEN, len must be in {1,3,7,15}.
  - Any violation sets AW_BURST or AR_BURST; the burst is still pushed.
- Write tracking:
  - Each AW handshake pushes awlen into the write length FIFO.
  - A W handshake checks against the FIFO head, or against the same-cycle AW if the FIFO is empty (bypass).
  - If no length is available, set W_ORDER and ignore the beat.
  - Beat counter compares against the head length. On beat == len, wlast must be 1; on beat < len, wlast must be 0; a mismatch sets WLAST.
  - Resync rule: the burst completes on whichever comes first, wlast or beat == len. On completion, pop the FIFO, clear the counter and increment the completed-write counter.
- B handshake: legal if the completed-write counter > 0 or a completion occurs the same cycle; it then decrements. Otherwise set W_ORDER.
- Read tracking: same scheme on the read length FIFO with R beats/rlast. An R beat with no length available sets R_ORDER. An rlast mismatch sets RLAST, with the same resync rule.
- Overflow: a push into a full FIFO (without a same-cycle pop) sets OVERFLOW and the push is dropped.
- wr_outstanding/rd_outstanding equal the respective FIFO occupancy. A push and a pop in the same cycle leave it unchanged.
- Error reporting:
  - err_sticky |= new bits.
  - err_pulse = |new bits.
  - When err_sticky was 0, first_err = lowest index among the new bits.
  - err_clr zeroes err_sticky and first_err; new errors in the same cycle take priority over the clear and are loaded.

Decomposition:
- Package axi_chk_pkg: error-bit index localparams (ERR_AW_STABLE..ERR_OVERFLOW), NUM_ERR=12, and the burst encodings FIXED=0, INCR=1, WRAP=2, RSVD=3.
- Sub-module axi_chk_len_fifo (DEPTH x 4 bit, push/pop/full/empty/count), instantiated twice, for write and read.

Test Plan:
- AW len=3 INCR, 4 W beats with wlast on beat 4, then B -> err_sticky=0; wr_outstanding goes 1 then 0.
- AW len=3, wlast on beat 2 -> err_sticky[7]=1, err_pulse high for exactly 1 cycle, first_err=7; the next legal burst raises no new error.
- awvalid=1, awready=0 at edge N, awaddr changes at N+1 -> bit 0 set; repeat with awvalid dropped -> bit 0 set.
- AR with arburst=2, arlen=2, araddr=0x2, arsize=2 -> bit 6 set. AR with arburst=3 -> bit 6 set.
- DEPTH+1 AR handshakes with no R -> bit 11 set, rd_outstanding=DEPTH; a B with no prior write -> bit 9 set, first_err=11.
- Assert resetn low mid-burst -> all outputs 0. After release, a legal burst is clean. err_clr pulsed with no new error in that cycle -> err_sticky=0, first_err=0.

Source files
------------

// File: rtl/axi_protocol_checker_pkg.sv
// Shared definitions for the AXI3 protocol checker: error-bit indices,
// burst encodings and small helpers used by the checker top.
package axi_chk_pkg;

    localparam int NUM_ERR       = 12;
    localparam int ERR_AW_STABLE = 0;
    localparam int ERR_W_STABLE  = 1;
    localparam int ERR_AR_STABLE = 2;
    localparam int ERR_B_STABLE  = 3;
    localparam int ERR_R_STABLE  = 4;
    localparam int ERR_AW_BURST  = 5;
    localparam int ERR_AR_BURST  = 6;
    localparam int ERR_WLAST     = 7;
    localparam int ERR_RLAST     = 8;
    localparam int ERR_W_ORDER   = 9;
    localparam int ERR_R_ORDER   = 10;
    localparam int ERR_OVERFLOW  = 11;

    localparam logic [1:0] FIXED = 2'd0;
    localparam logic [1:0] INCR  = 2'd1;
    localparam logic [1:0] WRAP  = 2'd2;
    localparam logic [1:0] RSVD  = 2'd3;

    // Lowest set bit index; 0 when nothing is set.
    function automatic logic [3:0] first_idx(input logic [NUM_ERR-1:0] v);
        first_idx = 4'd0;
        for (int i = NUM_ERR - 1; i >= 0; i--)
            if (v[i]) first_idx = 4'(i);
    endfunction

    // Illegal burst: reserved type, oversized beat, or a misaligned /
    // wrong-length wrap burst.
    function automatic logic burst_bad(input logic [1:0] burst, input logic [2:0] size,
                                       input logic [6:0] addr_lo, input logic [3:0] len,
                                       input logic [2:0] max_size, input logic chk_len);
        logic [6:0] mask;
        mask      = (7'd1 << size) - 7'd1;
        burst_bad = (burst == RSVD) || (size > max_size);
        if (burst == WRAP) begin
            if ((addr_lo & mask) != 7'd0) burst_bad = 1'b1;
            if (chk_len && !(len inside {4'd1, 4'd3, 4'd7, 4'd15})) burst_bad = 1'b1;
        end
    endfunction

endpackage

// File: rtl/axi_protocol_checker_if.sv
// AXI3 link bundle. The checker taps it through the mon modport.
interface axi_protocol_checker_if #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic [3:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              awvalid, awready;
    logic [ID_W-1:0]   wid;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wlast, wvalid, wready;
    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              bvalid, bready;
    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [3:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arvalid, arready;
    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast, rvalid, rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
        output wid, wdata, wstrb, wlast, wvalid, input wready,
        input bid, bresp, bvalid, output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
        input rid, rdata, rresp, rlast, rvalid, output rready
    );

    modport slave (
        input awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
        input wid, wdata, wstrb, wlast, wvalid, output wready,
        output bid, bresp, bvalid, input bready,
        input arid, araddr, arlen, arsize, arburst, arvalid, output arready,
        output rid, rdata, rresp, rlast, rvalid, input rready
    );

    modport mon (
        input awid, awaddr, awlen, awsize, awburst, awvalid, awready,
        input wid, wdata, wstrb, wlast, wvalid, wready,
        input bid, bresp, bvalid, bready,
        input arid, araddr, arlen, arsize, arburst, arvalid, arready,
        input rid, rdata, rresp, rlast, rvalid, rready
    );
endinterface

// File: rtl/axi_chk_len_fifo.sv
// Small FIFO of burst lengths. Callers never pop when empty and never
// push into a full FIFO unless popping in the same cycle.
module axi_chk_len_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 4
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr, rptr;

    assign dout  = mem[rptr];
    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);

    // Storage write; contents need no reset since count gates every read.
    always_ff @(posedge clk)
        if (push) mem[wptr] <= din;

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/axi_protocol_checker.sv
// Passive AXI3 protocol checker: handshake stability, burst legality,
// beat counting against wlast/rlast and response ordering.
module axi_protocol_checker
    import axi_chk_pkg::*;
#(
    parameter int ID_W         = 4,
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 8,
    parameter int CHK_WRAP_LEN = 1
) (
    input  logic                   clk,
    input  logic                   resetn,
    axi_protocol_checker_if.mon    bus,
    input  logic                   err_clr,
    output logic [NUM_ERR-1:0]     err_sticky,
    output logic                   err_pulse,
    output logic [3:0]             first_err,
    output logic [$clog2(DEPTH):0] wr_outstanding,
    output logic [$clog2(DEPTH):0] rd_outstanding
);
    localparam int STRB_W = DATA_W / 8;
    localparam logic [2:0] MAX_SIZE = 3'($clog2(STRB_W));
    localparam logic CHK_LEN = (CHK_WRAP_LEN != 0);
    localparam int AW_PL = ID_W + ADDR_W + 9;
    localparam int W_PL  = ID_W + DATA_W + STRB_W + 1;
    localparam int B_PL  = ID_W + 2;
    localparam int R_PL  = ID_W + DATA_W + 3;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    assign aw_hs = bus.awvalid && bus.awready;
    assign w_hs  = bus.wvalid  && bus.wready;
    assign b_hs  = bus.bvalid  && bus.bready;
    assign ar_hs = bus.arvalid && bus.arready;
    assign r_hs  = bus.rvalid  && bus.rready;

    logic [AW_PL-1:0] aw_pl, aw_pl_q, ar_pl, ar_pl_q;
    logic [W_PL-1:0]  w_pl, w_pl_q;
    logic [B_PL-1:0]  b_pl, b_pl_q;
    logic [R_PL-1:0]  r_pl, r_pl_q;
    logic aw_pend, w_pend, b_pend, ar_pend, r_pend;
    assign aw_pl = {bus.awid, bus.awaddr, bus.awlen, bus.awsize, bus.awburst};
    assign ar_pl = {bus.arid, bus.araddr, bus.arlen, bus.arsize, bus.arburst};
    assign w_pl  = {bus.wid, bus.wdata, bus.wstrb, bus.wlast};
    assign b_pl  = {bus.bid, bus.bresp};
    assign r_pl  = {bus.rid, bus.rdata, bus.rresp, bus.rlast};

    // Remember stalled transfers so the next edge can be held to them.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            {aw_pend, w_pend, b_pend, ar_pend, r_pend} <= '0;
            aw_pl_q <= '0; w_pl_q <= '0; b_pl_q <= '0; ar_pl_q <= '0; r_pl_q <= '0;
        end else begin
            aw_pend <= bus.awvalid && !bus.awready;
            w_pend  <= bus.wvalid  && !bus.wready;
            b_pend  <= bus.bvalid  && !bus.bready;
            ar_pend <= bus.arvalid && !bus.arready;
            r_pend  <= bus.rvalid  && !bus.rready;
            aw_pl_q <= aw_pl; w_pl_q <= w_pl; b_pl_q <= b_pl; ar_pl_q <= ar_pl; r_pl_q <= r_pl;
        end
    end

    // Write path: FIFO head, or the same-cycle AW when the FIFO is empty.
    logic [3:0] wf_head, w_len, wcnt;
    logic       wf_full, wf_empty, wf_push, wf_pop, wf_req, wr_ovf;
    logic       w_avail, w_beat, w_done, b_ok;
    logic [7:0] bcnt;
    assign w_avail = !wf_empty || aw_hs;
    assign w_len   = wf_empty ? bus.awlen : wf_head;
    assign w_beat  = w_hs && w_avail;
    assign w_done  = w_beat && (bus.wlast || wcnt == w_len);
    assign wf_pop  = w_done && !wf_empty;
    // A bypassed burst that completes in its own AW cycle is never stored.
    assign wf_req  = aw_hs && !(wf_empty && w_done);
    assign wr_ovf  = wf_req && wf_full && !wf_pop;
    assign wf_push = wf_req && !wr_ovf;
    assign b_ok    = (bcnt != 8'd0) || w_done;

    axi_chk_len_fifo #(.DEPTH(DEPTH), .W(4)) u_wr_fifo (
        .clk(clk), .resetn(resetn), .push(wf_push), .pop(wf_pop), .din(bus.awlen),
        .dout(wf_head), .full(wf_full), .empty(wf_empty), .count(wr_outstanding)
    );

    // Read path mirrors the write path without a response channel.
    logic [3:0] rf_head, r_len, rcnt;
    logic       rf_full, rf_empty, rf_push, rf_pop, rf_req, rd_ovf;
    logic       r_avail, r_beat, r_done;
    assign r_avail = !rf_empty || ar_hs;
    assign r_len   = rf_empty ? bus.arlen : rf_head;
    assign r_beat  = r_hs && r_avail;
    assign r_done  = r_beat && (bus.rlast || rcnt == r_len);
    assign rf_pop  = r_done && !rf_empty;
    assign rf_req  = ar_hs && !(rf_empty && r_done);
    assign rd_ovf  = rf_req && rf_full && !rf_pop;
    assign rf_push = rf_req && !rd_ovf;

    axi_chk_len_fifo #(.DEPTH(DEPTH), .W(4)) u_rd_fifo (
        .clk(clk), .resetn(resetn), .push(rf_push), .pop(rf_pop), .din(bus.arlen),
        .dout(rf_head), .full(rf_full), .empty(rf_empty), .count(rd_outstanding)
    );

    // Beat counters and the completed-write count awaiting B.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wcnt <= '0;
            rcnt <= '0;
            bcnt <= '0;
        end else begin
            if (w_done)      wcnt <= '0;
            else if (w_beat) wcnt <= wcnt + 1'b1;
            if (r_done)      rcnt <= '0;
            else if (r_beat) rcnt <= rcnt + 1'b1;
            if (w_done && !(b_hs && b_ok)) begin
                if (bcnt != 8'hFF) bcnt <= bcnt + 1'b1;
            end else if (!w_done && b_hs && b_ok) begin
                bcnt <= bcnt - 1'b1;
            end
        end
    end

    // Error bits detected at this edge.
    logic [NUM_ERR-1:0] new_err;
    always_comb begin
        new_err = '0;
        new_err[ERR_AW_STABLE] = aw_pend && (!bus.awvalid || aw_pl != aw_pl_q);
        new_err[ERR_W_STABLE]  = w_pend  && (!bus.wvalid  || w_pl  != w_pl_q);
        new_err[ERR_B_STABLE]  = b_pend  && (!bus.bvalid  || b_pl  != b_pl_q);
        new_err[ERR_AR_STABLE] = ar_pend && (!bus.arvalid || ar_pl != ar_pl_q);
        new_err[ERR_R_STABLE]  = r_pend  && (!bus.rvalid  || r_pl  != r_pl_q);
        new_err[ERR_AW_BURST]  = aw_hs && burst_bad(bus.awburst, bus.awsize, bus.awaddr[6:0],
                                                    bus.awlen, MAX_SIZE, CHK_LEN);
        new_err[ERR_AR_BURST]  = ar_hs && burst_bad(bus.arburst, bus.arsize, bus.araddr[6:0],
                                                    bus.arlen, MAX_SIZE, CHK_LEN);
        new_err[ERR_WLAST]     = w_beat && ((wcnt == w_len) != bus.wlast);
        new_err[ERR_RLAST]     = r_beat && ((rcnt == r_len) != bus.rlast);
        new_err[ERR_W_ORDER]   = (w_hs && !w_avail) || (b_hs && !b_ok);
        new_err[ERR_R_ORDER]   = r_hs && !r_avail;
        new_err[ERR_OVERFLOW]  = wr_ovf || rd_ovf;
    end

    // Sticky/first-error reporting; fresh errors win over a clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_sticky <= '0;
            err_pulse  <= 1'b0;
            first_err  <= '0;
        end else begin
            err_pulse <= |new_err;
            if (err_clr) begin
                err_sticky <= new_err;
                first_err  <= first_idx(new_err);
            end else begin
                err_sticky <= err_sticky | new_err;
                if (err_sticky == '0 && |new_err) first_err <= first_idx(new_err);
            end
        end
    end
endmodule

// File: tb/tb_axi_protocol_checker.sv
// Directed bench for axi_protocol_checker with hand-computed expectations.
module tb_axi_protocol_checker;
    import axi_chk_pkg::*;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        err_clr = 1'b0;
    logic [11:0] err_sticky;
    logic        err_pulse;
    logic [3:0]  first_err;
    logic [3:0]  wr_outstanding, rd_outstanding;
    int vec = 0;
    int miscmp = 0;

    axi_protocol_checker_if #(.ID_W(4), .ADDR_W(32), .DATA_W(32)) axi ();

    axi_protocol_checker #(.ID_W(4), .ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .CHK_WRAP_LEN(1)) dut (
        .clk(clk), .resetn(resetn), .bus(axi), .err_clr(err_clr),
        .err_sticky(err_sticky), .err_pulse(err_pulse), .first_err(first_err),
        .wr_outstanding(wr_outstanding), .rd_outstanding(rd_outstanding)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_aw(input logic v, input logic [31:0] a, input logic [3:0] l,
                          input logic [1:0] bu, input logic [2:0] sz);
        axi.awvalid = v; axi.awready = v; axi.awid = 4'h1;
        axi.awaddr = a; axi.awlen = l; axi.awburst = bu; axi.awsize = sz;
    endtask

    task automatic set_ar(input logic v, input logic [31:0] a, input logic [3:0] l,
                          input logic [1:0] bu, input logic [2:0] sz);
        axi.arvalid = v; axi.arready = v; axi.arid = 4'h2;
        axi.araddr = a; axi.arlen = l; axi.arburst = bu; axi.arsize = sz;
    endtask

    task automatic set_w(input logic v, input logic last);
        axi.wvalid = v; axi.wready = v; axi.wid = 4'h1;
        axi.wdata = 32'hA5A5_0000; axi.wstrb = 4'hF; axi.wlast = last;
    endtask

    task automatic set_b(input logic v);
        axi.bvalid = v; axi.bready = v; axi.bid = 4'h1; axi.bresp = 2'd0;
    endtask

    task automatic set_r(input logic v, input logic last);
        axi.rvalid = v; axi.rready = v; axi.rid = 4'h2;
        axi.rdata = 32'h5A5A_0000; axi.rresp = 2'd0; axi.rlast = last;
    endtask

    task automatic idle();
        set_aw(0, 0, 0, INCR, 0); set_ar(0, 0, 0, INCR, 0);
        set_w(0, 0); set_b(0); set_r(0, 0);
    endtask

    task automatic clear();
        err_clr = 1'b1; tick(); err_clr = 1'b0;
    endtask

    task automatic test_reset();
        idle(); resetn = 1'b0;
        repeat (3) tick();
        vec++; if (err_sticky !== 12'h000) begin miscmp++; $display("FAIL reset_sticky got %h exp 000", err_sticky); end
        vec++; if (err_pulse !== 1'b0) begin miscmp++; $display("FAIL reset_pulse got %b exp 0", err_pulse); end
        vec++; if (first_err !== 4'd0) begin miscmp++; $display("FAIL reset_first got %0d exp 0", first_err); end
        vec++; if (wr_outstanding !== 4'd0) begin miscmp++; $display("FAIL reset_wr_out got %0d exp 0", wr_outstanding); end
        vec++; if (rd_outstanding !== 4'd0) begin miscmp++; $display("FAIL reset_rd_out got %0d exp 0", rd_outstanding); end
        resetn = 1'b1; tick();
    endtask

    task automatic test_write_ok();
        set_aw(1, 32'h100, 4'd3, INCR, 3'd2); tick(); set_aw(0, 0, 0, INCR, 0);
        vec++; if (wr_outstanding !== 4'd1) begin miscmp++; $display("FAIL wr_ok_out1 got %0d exp 1", wr_outstanding); end
        set_w(1, 0); repeat (3) tick();
        vec++; if (wr_outstanding !== 4'd1) begin miscmp++; $display("FAIL wr_ok_mid got %0d exp 1", wr_outstanding); end
        set_w(1, 1); tick(); set_w(0, 0);
        vec++; if (wr_outstanding !== 4'd0) begin miscmp++; $display("FAIL wr_ok_out0 got %0d exp 0", wr_outstanding); end
        set_b(1); tick(); set_b(0);
        vec++; if (err_sticky !== 12'h000) begin miscmp++; $display("FAIL wr_ok_sticky got %h exp 000", err_sticky); end
    endtask

    task automatic test_wlast_err();
        set_aw(1, 32'h100, 4'd3, INCR, 3'd2); tick(); set_aw(0, 0, 0, INCR, 0);
        set_w(1, 0); tick(); set_w(1, 1); tick(); set_w(0, 0);
        vec++; if (err_sticky !== 12'h080) begin miscmp++; $display("FAIL wlast_sticky got %h exp 080", err_sticky); end
        vec++; if (err_pulse !== 1'b1) begin miscmp++; $display("FAIL wlast_pulse_hi got %b exp 1", err_pulse); end
        vec++; if (first_err !== 4'd7) begin miscmp++; $display("FAIL wlast_first got %0d exp 7", first_err); end
        vec++; if (wr_outstanding !== 4'd0) begin miscmp++; $display("FAIL wlast_resync got %0d exp 0", wr_outstanding); end
        set_b(1); tick(); set_b(0);
        vec++; if (err_pulse !== 1'b0) begin miscmp++; $display("FAIL wlast_pulse_lo got %b exp 0", err_pulse); end
        set_aw(1, 32'h140, 4'd0, INCR, 3'd2); tick(); set_aw(0, 0, 0, INCR, 0);
        set_w(1, 1); tick(); set_w(0, 0); set_b(1); tick(); set_b(0);
        vec++; if (err_sticky !== 12'h080) begin miscmp++; $display("FAIL wlast_after got %h exp 080", err_sticky); end
        vec++; if (err_pulse !== 1'b0) begin miscmp++; $display("FAIL wlast_after_pulse got %b exp 0", err_pulse); end
        clear();
        vec++; if (err_sticky !== 12'h000) begin miscmp++; $display("FAIL wlast_clr got %h exp 000", err_sticky); end
    endtask

    task automatic test_aw_stable();
        set_aw(1, 32'h200, 4'd0, INCR, 3'd2); axi.awready = 1'b0; tick();
        axi.awaddr = 32'h204; tick();
        vec++; if (err_sticky !== 12'h001) begin miscmp++; $display("FAIL aw_stab_addr got %h exp 001", err_sticky); end
        vec++; if (err_pulse !== 1'b1) begin miscmp++; $display("FAIL aw_stab_pulse got %b exp 1", err_pulse); end
        set_aw(0, 0, 0, INCR, 0); tick(); clear();
        vec++; if (err_sticky !== 12'h000) begin miscmp++; $display("FAIL aw_stab_clr got %h exp 000", err_sticky); end
        set_aw(1, 32'h200, 4'd0, INCR, 3'd2); axi.awready = 1'b0; tick();
        set_aw(0, 0, 0, INCR, 0); tick();
        vec++; if (err_sticky !== 12'h001) begin miscmp++; $display("FAIL aw_stab_drop got %h exp 001", err_sticky); end
        clear();
    endtask

    task automatic test_ar_burst();
        set_ar(1, 32'h2, 4'd2, WRAP, 3'd2); tick(); set_ar(0, 0, 0, INCR, 0);
        vec++; if (err_sticky !== 12'h040) begin miscmp++; $display("FAIL ar_wrap got %h exp 040", err_sticky); end
        vec++; if (first_err !== 4'd6) begin miscmp++; $display("FAIL ar_wrap_first got %0d exp 6", first_err); end
        vec++; if (rd_outstanding !== 4'd1) begin miscmp++; $display("FAIL ar_wrap_pushed got %0d exp 1", rd_outstanding); end
        set_r(1, 0); repeat (2) tick(); set_r(1, 1); tick(); set_r(0, 0);
        vec++; if (rd_outstanding !== 4'd0) begin miscmp++; $display("FAIL ar_wrap_drain got %0d exp 0", rd_outstanding); end
        clear();
        set_ar(1, 32'h0, 4'd0, RSVD, 3'd2); tick(); set_ar(0, 0, 0, INCR, 0);
        vec++; if (err_sticky !== 12'h040) begin miscmp++; $display("FAIL ar_rsvd got %h exp 040", err_sticky); end
        set_r(1, 1); tick(); set_r(0, 0); clear();
        set_ar(1, 32'h10, 4'd3, WRAP, 3'd2); tick(); set_ar(0, 0, 0, INCR, 0);
        set_r(1, 0); repeat (3) tick(); set_r(1, 1); tick(); set_r(0, 0);
        vec++; if (err_sticky !== 12'h000) begin miscmp++; $display("FAIL ar_wrap_legal got %h exp 000", err_sticky); end
    endtask

    task automatic test_back_to_back();
        set_aw(1, 32'h300, 4'd0, INCR, 3'd2); set_w(1, 1); tick();
        set_aw(0, 0, 0, INCR, 0); set_w(0, 0);
        vec++; if (wr_outstanding !== 4'd0) begin miscmp++; $display("FAIL bypass_out got %0d exp 0", wr_outstanding); end
        set_b(1); tick(); set_b(0);
        set_aw(1, 32'h310, 4'd1, INCR, 3'd2); set_w(1, 0); tick(); set_aw(0, 0, 0, INCR, 0);
        vec++; if (wr_outstanding !== 4'd1) begin miscmp++; $display("FAIL bypass_push got %0d exp 1", wr_outstanding); end
        set_w(1, 1); set_b(1); tick(); set_w(0, 0); set_b(0);
        vec++; if (wr_outstanding !== 4'd0) begin miscmp++; $display("FAIL bypass_pop got %0d exp 0", wr_outstanding); end
        vec++; if (err_sticky !== 12'h000) begin miscmp++; $display("FAIL bypass_sticky got %h exp 000", err_sticky); end
    endtask

    task automatic test_order();
        set_w(1, 1); set_r(1, 1); tick(); set_w(0, 0); set_r(0, 0);
        vec++; if (err_sticky !== 12'h600) begin miscmp++; $display("FAIL order_sticky got %h exp 600", err_sticky); end
        vec++; if (first_err !== 4'd9) begin miscmp++; $display("FAIL order_first got %0d exp 9", first_err); end
        clear();
    endtask

    task automatic test_overflow();
        set_ar(1, 32'h400, 4'd0, INCR, 3'd2); repeat (DEPTH + 1) tick(); set_ar(0, 0, 0, INCR, 0);
        vec++; if (err_sticky !== 12'h800) begin miscmp++; $display("FAIL ovf_sticky got %h exp 800", err_sticky); end
        vec++; if (rd_outstanding !== 4'(DEPTH)) begin miscmp++; $display("FAIL ovf_rd_out got %0d exp %0d", rd_outstanding, DEPTH); end
        vec++; if (first_err !== 4'd11) begin miscmp++; $display("FAIL ovf_first got %0d exp 11", first_err); end
        set_b(1); tick(); set_b(0);
        vec++; if (err_sticky !== 12'hA00) begin miscmp++; $display("FAIL b_order got %h exp a00", err_sticky); end
        vec++; if (first_err !== 4'd11) begin miscmp++; $display("FAIL b_order_first got %0d exp 11", first_err); end
        set_r(1, 1); repeat (DEPTH) tick(); set_r(0, 0);
        vec++; if (rd_outstanding !== 4'd0) begin miscmp++; $display("FAIL ovf_drain got %0d exp 0", rd_outstanding); end
        vec++; if (err_sticky !== 12'hA00) begin miscmp++; $display("FAIL ovf_drain_sticky got %h exp a00", err_sticky); end
    endtask

    task automatic test_reset_mid();
        set_aw(1, 32'h500, 4'd3, INCR, 3'd2); tick(); set_aw(0, 0, 0, INCR, 0);
        set_w(1, 0); repeat (2) tick(); set_w(0, 0);
        vec++; if (wr_outstanding !== 4'd1) begin miscmp++; $display("FAIL mid_pre got %0d exp 1", wr_outstanding); end
        #2 resetn = 1'b0; #1;
        vec++; if (err_sticky !== 12'h000) begin miscmp++; $display("FAIL mid_rst_sticky got %h exp 000", err_sticky); end
        vec++; if (wr_outstanding !== 4'd0) begin miscmp++; $display("FAIL mid_rst_wr got %0d exp 0", wr_outstanding); end
        vec++; if (first_err !== 4'd0) begin miscmp++; $display("FAIL mid_rst_first got %0d exp 0", first_err); end
        repeat (2) tick(); resetn = 1'b1; tick();
        set_aw(1, 32'h600, 4'd1, INCR, 3'd2); tick(); set_aw(0, 0, 0, INCR, 0);
        set_w(1, 0); tick(); set_w(1, 1); tick(); set_w(0, 0); set_b(1); tick(); set_b(0);
        vec++; if (err_sticky !== 12'h000) begin miscmp++; $display("FAIL mid_after got %h exp 000", err_sticky); end
        vec++; if (wr_outstanding !== 4'd0) begin miscmp++; $display("FAIL mid_after_wr got %0d exp 0", wr_outstanding); end
    endtask

    task automatic test_err_clr();
        set_r(1, 1); tick(); set_r(0, 0);
        vec++; if (first_err !== 4'd10) begin miscmp++; $display("FAIL clr_pre_first got %0d exp 10", first_err); end
        err_clr = 1'b1; set_w(1, 1); tick(); err_clr = 1'b0; set_w(0, 0);
        vec++; if (err_sticky !== 12'h200) begin miscmp++; $display("FAIL clr_prio got %h exp 200", err_sticky); end
        vec++; if (first_err !== 4'd9) begin miscmp++; $display("FAIL clr_prio_first got %0d exp 9", first_err); end
        clear();
        vec++; if (err_sticky !== 12'h000) begin miscmp++; $display("FAIL clr_sticky got %h exp 000", err_sticky); end
        vec++; if (first_err !== 4'd0) begin miscmp++; $display("FAIL clr_first got %0d exp 0", first_err); end
        vec++; if (err_pulse !== 1'b0) begin miscmp++; $display("FAIL clr_pulse got %b exp 0", err_pulse); end
    endtask

    initial begin
        test_reset();
        test_write_ok();
        test_wlast_err();
        test_aw_stable();
        test_ar_burst();
        test_back_to_back();
        test_order();
        test_overflow();
        test_reset_mid();
        test_err_clr();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
        $finish;
    end
endmodule
